multi_phase_traffic_controller: RTL and testbench

MULTI_PHASE_TRAFFIC_CONTROLLER -- requirements
Module: multi_phase_traffic_controller

---
 rtl/multi_phase_traffic_controller.sv | 183 ++++++++++++++++++
 tb/tb_multi_phase_traffic_controller.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_phase_traffic_controller.sv
// Multi-phase traffic signal controller: round-robin GREEN/YELLOW/ALL_RED
// sequencing with pedestrian walk service, gap-out and emergency preemption.
module multi_phase_traffic_controller #(
  parameter int NUM_PHASES   = 4,
  parameter int GREEN_TIME   = 128,
  parameter int MIN_GREEN    = 16,
  parameter int YELLOW_TIME  = 8,
  parameter int ALL_RED_TIME = 2,
  parameter int WALK_TIME    = 30,
  parameter int TIMER_W      = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_PHASES-1:0]           ped_req,
  input  logic                            emerg_req,
  input  logic [$clog2(NUM_PHASES)-1:0]   emerg_phase,
  output logic [2*NUM_PHASES-1:0]         phase_light,
  output logic [NUM_PHASES-1:0]           walk,
  output logic [$clog2(NUM_PHASES)-1:0]   active_phase,
  output logic [NUM_PHASES-1:0]           ped_pending
);

  localparam int PW = $clog2(NUM_PHASES);

  localparam logic [PW-1:0]      LAST     = PW'(NUM_PHASES - 1);
  localparam logic [TIMER_W-1:0] T_ONE    = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] T_GREEN  = TIMER_W'(GREEN_TIME);
  localparam logic [TIMER_W-1:0] T_MIN    = TIMER_W'(MIN_GREEN);
  localparam logic [TIMER_W-1:0] T_YELLOW = TIMER_W'(YELLOW_TIME);
  localparam logic [TIMER_W-1:0] T_ALLRED = TIMER_W'(ALL_RED_TIME);
  localparam logic [TIMER_W-1:0] T_WALK   = TIMER_W'(WALK_TIME);
  // Timer value at which MIN_GREEN cycles of green have elapsed.
  localparam logic [TIMER_W-1:0] GAP_AT   = TIMER_W'(GREEN_TIME - MIN_GREEN + 1);

  localparam logic [1:0] L_RED    = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_GREEN  = 2'b10;

  typedef enum logic [1:0] {
    S_GREEN   = 2'd0,
    S_YELLOW  = 2'd1,
    S_ALL_RED = 2'd2
  } state_t;

  state_t                state, state_d;
  logic [PW-1:0]         phase, phase_d, next_rr;
  logic [TIMER_W-1:0]    timer, timer_d, t_eff;
  logic [TIMER_W-1:0]    walk_cnt, walk_cnt_d;
  logic                  held, held_d;
  logic                  resumed, resumed_d;
  logic [NUM_PHASES-1:0] pending, pending_d, sel, clear_mask;
  logic                  emerg_valid, hold_here, preempt, gap_ok, other_pending, walk_on;

  // Out-of-range emergency phases are ignored; with a power-of-two phase count
  // every encoding is in range.
  if ((2 ** PW) == NUM_PHASES) begin : g_full
    assign emerg_valid = emerg_req;
  end else begin : g_partial
    assign emerg_valid = emerg_req && (emerg_phase < PW'(NUM_PHASES));
  end

  // Per-cycle decision terms derived from current state and inputs.
  always_comb begin
    next_rr       = (phase == LAST) ? '0 : phase + 1'b1;
    sel           = NUM_PHASES'(1) << phase;
    hold_here     = (state == S_GREEN) && emerg_valid && (emerg_phase == phase);
    preempt       = (state == S_GREEN) && emerg_valid && (emerg_phase != phase);
    // On the first cycle after an emergency hold is released the timer
    // behaves as if reloaded with MIN_GREEN, so that cycle counts toward it.
    t_eff         = (held && !hold_here) ? T_MIN : timer;
    gap_ok        = (t_eff <= GAP_AT) || resumed || held;
    other_pending = |(pending & ~sel);
    walk_on       = (state == S_GREEN) && (walk_cnt != '0) && !hold_here;
  end

  // Next-state, timer and walk-counter logic for the signal sequence.
  always_comb begin
    state_d    = state;
    phase_d    = phase;
    timer_d    = timer;
    walk_cnt_d = walk_cnt;
    held_d     = held;
    resumed_d  = resumed;
    clear_mask = '0;
    unique case (state)
      S_GREEN: begin
        if (hold_here) begin
          held_d     = 1'b1;
          walk_cnt_d = '0;
        end else if (preempt || (t_eff == T_ONE) || (gap_ok && other_pending)) begin
          state_d    = S_YELLOW;
          timer_d    = T_YELLOW;
          walk_cnt_d = '0;
          held_d     = 1'b0;
          resumed_d  = 1'b0;
        end else begin
          timer_d = t_eff - 1'b1;
          if (walk_cnt != '0) begin
            walk_cnt_d = walk_cnt - 1'b1;
          end
          if (held) begin
            held_d    = 1'b0;
            resumed_d = 1'b1;
          end
        end
      end
      S_YELLOW: begin
        if (timer == T_ONE) begin
          state_d = S_ALL_RED;
          timer_d = T_ALLRED;
        end else begin
          timer_d = timer - 1'b1;
        end
      end
      S_ALL_RED: begin
        if (timer == T_ONE) begin
          state_d = S_GREEN;
          timer_d = T_GREEN;
          if (emerg_valid) begin
            phase_d = emerg_phase;
          end else begin
            phase_d = next_rr;
            if (pending[next_rr]) begin
              walk_cnt_d = T_WALK;
              clear_mask = NUM_PHASES'(1) << next_rr;
            end
          end
        end else begin
          timer_d = timer - 1'b1;
        end
      end
      default: begin
        state_d = S_GREEN;
        timer_d = T_GREEN;
      end
    endcase
  end

  // Pedestrian latch: presses are ignored while that phase is walking; a
  // grant clears the bit on the same edge that starts the walk.
  always_comb begin
    pending_d = (pending | (ped_req & ~walk)) & ~clear_mask;
  end

  // State registers with asynchronous active-low reset to phase 0 green.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_GREEN;
      phase    <= '0;
      timer    <= T_GREEN;
      walk_cnt <= '0;
      held     <= 1'b0;
      resumed  <= 1'b0;
      pending  <= '0;
    end else begin
      state    <= state_d;
      phase    <= phase_d;
      timer    <= timer_d;
      walk_cnt <= walk_cnt_d;
      held     <= held_d;
      resumed  <= resumed_d;
      pending  <= pending_d;
    end
  end

  // Output decode: only the owning phase may be non-RED.
  always_comb begin
    phase_light = '0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      if (phase == PW'(i)) begin
        unique case (state)
          S_GREEN:  phase_light[2*i +: 2] = L_GREEN;
          S_YELLOW: phase_light[2*i +: 2] = L_YELLOW;
          default:  phase_light[2*i +: 2] = L_RED;
        endcase
      end
    end
    walk         = walk_on ? sel : '0;
    active_phase = phase;
    ped_pending  = pending;
  end

endmodule

// File: tb/tb_multi_phase_traffic_controller.sv
// Self-checking bench for multi_phase_traffic_controller: directed scenarios
// plus randomized traffic against a cycle-count reference model.
module tb_multi_phase_traffic_controller;

  localparam int N  = 4;
  localparam int GT = 20;
  localparam int MG = 5;
  localparam int YT = 3;
  localparam int AT = 2;
  localparam int WT = 7;
  localparam int TW = 8;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   ped_req = '0;
  logic           emerg_req = 1'b0;
  logic [1:0]     emerg_phase = '0;
  logic [2*N-1:0] phase_light;
  logic [N-1:0]   walk;
  logic [1:0]     active_phase;
  logic [N-1:0]   ped_pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multi_phase_traffic_controller #(
    .NUM_PHASES  (N),
    .GREEN_TIME  (GT),
    .MIN_GREEN   (MG),
    .YELLOW_TIME (YT),
    .ALL_RED_TIME(AT),
    .WALK_TIME   (WT),
    .TIMER_W     (TW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ped_req     (ped_req),
    .emerg_req   (emerg_req),
    .emerg_phase (emerg_phase),
    .phase_light (phase_light),
    .walk        (walk),
    .active_phase(active_phase),
    .ped_pending (ped_pending)
  );

  // color: 0 red, 1 yellow, 2 green
  function automatic logic [2*N-1:0] lights(int p, int color);
    logic [2*N-1:0] v;
    v = '0;
    if (color == 1) v[2*p +: 2] = 2'b01;
    if (color == 2) v[2*p +: 2] = 2'b10;
    return v;
  endfunction

  function automatic logic [N-1:0] onehot(int p);
    logic [N-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  // Leaves the bench at posedge+1 of cycle 0 after release.
  task automatic do_reset();
    reset_n = 1'b0;
    ped_req = '0;
    emerg_req = 1'b0;
    emerg_phase = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    #2;
    checks++;
    if (phase_light !== lights(0, 2)) begin
      errors++; $display("FAIL reset_light got=%b exp=%b", phase_light, lights(0, 2));
    end
    checks++;
    if (walk !== '0 || ped_pending !== '0 || active_phase !== 2'd0) begin
      errors++; $display("FAIL reset_regs walk=%b pend=%b act=%0d exp 0/0/0", walk, ped_pending, active_phase);
    end
    @(posedge clk); #1;
    checks++;
    if (phase_light !== lights(0, 2)) begin
      errors++; $display("FAIL reset_hold_light got=%b exp=%b", phase_light, lights(0, 2));
    end
    reset_n = 1'b1;
  endtask

  task automatic test_rotation();
    do_reset();
    for (int c = 0; c <= 100; c++) begin
      int seg, p, col;
      seg = c % 25;
      p   = (c / 25) % N;
      col = (seg < GT) ? 2 : (seg < GT + YT) ? 1 : 0;
      @(negedge clk);
      checks++;
      if (phase_light !== lights(p, col)) begin
        errors++; $display("FAIL rotation_light c=%0d got=%b exp=%b", c, phase_light, lights(p, col));
      end
      checks++;
      if (active_phase !== 2'(p)) begin
        errors++; $display("FAIL rotation_active c=%0d got=%0d exp=%0d", c, active_phase, p);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ped_gapout();
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      logic [2*N-1:0] el;
      logic [N-1:0]   ep, ew;
      int ea;
      ped_req = (c == 2) ? 4'b0100 : 4'b0000;
      if (c < 5)       el = lights(0, 2);
      else if (c < 8)  el = lights(0, 1);
      else if (c < 10) el = lights(0, 0);
      else if (c < 15) el = lights(1, 2);
      else if (c < 18) el = lights(1, 1);
      else if (c < 20) el = lights(1, 0);
      else             el = lights(2, 2);
      ea = (c < 10) ? 0 : (c < 20) ? 1 : 2;
      ep = (c >= 3 && c < 20) ? 4'b0100 : 4'b0000;
      ew = (c >= 20 && c < 27) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      checks++;
      if (phase_light !== el) begin
        errors++; $display("FAIL gapout_light c=%0d got=%b exp=%b", c, phase_light, el);
      end
      checks++;
      if (active_phase !== 2'(ea)) begin
        errors++; $display("FAIL gapout_active c=%0d got=%0d exp=%0d", c, active_phase, ea);
      end
      checks++;
      if (ped_pending !== ep) begin
        errors++; $display("FAIL gapout_pending c=%0d got=%b exp=%b", c, ped_pending, ep);
      end
      checks++;
      if (walk !== ew) begin
        errors++; $display("FAIL gapout_walk c=%0d got=%b exp=%b", c, walk, ew);
      end
      @(posedge clk); #1;
    end
    ped_req = '0;
  endtask

  task automatic test_walk_ignore();
    do_reset();
    for (int c = 0; c <= 63; c++) begin
      logic [N-1:0] ep, ew;
      ped_req = ((c == 0) || (c >= 56 && c <= 63)) ? 4'b0001 : 4'b0000;
      ep = ((c >= 1 && c <= 54) || c == 63) ? 4'b0001 : 4'b0000;
      ew = (c >= 55 && c <= 61) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      checks++;
      if (ped_pending !== ep) begin
        errors++; $display("FAIL walkign_pending c=%0d got=%b exp=%b", c, ped_pending, ep);
      end
      checks++;
      if (walk !== ew) begin
        errors++; $display("FAIL walkign_walk c=%0d got=%b exp=%b", c, walk, ew);
      end
      if (c == 25 || c == 30 || c == 55) begin
        logic [2*N-1:0] el;
        el = (c == 25) ? lights(1, 2) : (c == 30) ? lights(1, 1) : lights(0, 2);
        checks++;
        if (phase_light !== el) begin
          errors++; $display("FAIL walkign_light c=%0d got=%b exp=%b", c, phase_light, el);
        end
      end
      @(posedge clk); #1;
    end
    ped_req = '0;
  endtask

  task automatic test_emergency();
    do_reset();
    for (int c = 0; c <= 51; c++) begin
      logic [2*N-1:0] el;
      logic [N-1:0]   ep;
      int ea;
      emerg_req   = (c >= 10 && c <= 40);
      emerg_phase = 2'd3;
      ped_req     = (c == 20) ? 4'b1000 : 4'b0000;
      if (c <= 10)      el = lights(0, 2);
      else if (c <= 13) el = lights(0, 1);
      else if (c <= 15) el = lights(0, 0);
      else if (c <= 45) el = lights(3, 2);
      else if (c <= 48) el = lights(3, 1);
      else if (c <= 50) el = lights(3, 0);
      else              el = lights(0, 2);
      ea = (c < 16) ? 0 : (c < 51) ? 3 : 0;
      ep = (c >= 21) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      checks++;
      if (phase_light !== el) begin
        errors++; $display("FAIL emerg_light c=%0d got=%b exp=%b", c, phase_light, el);
      end
      checks++;
      if (active_phase !== 2'(ea)) begin
        errors++; $display("FAIL emerg_active c=%0d got=%0d exp=%0d", c, active_phase, ea);
      end
      checks++;
      if (walk !== 4'b0000 || ped_pending !== ep) begin
        errors++; $display("FAIL emerg_ped c=%0d walk=%b pend=%b exp walk=0000 pend=%b", c, walk, ped_pending, ep);
      end
      @(posedge clk); #1;
    end
    emerg_req = 1'b0;
    ped_req = '0;
  endtask

  task automatic test_retarget();
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      logic [2*N-1:0] el;
      int ea;
      emerg_req   = (c >= 10 && c <= 16);
      emerg_phase = (c >= 14) ? 2'd1 : 2'd3;
      if (c <= 10)      el = lights(0, 2);
      else if (c <= 13) el = lights(0, 1);
      else if (c <= 15) el = lights(0, 0);
      else if (c <= 21) el = lights(1, 2);
      else              el = lights(1, 1);
      ea = (c < 16) ? 0 : 1;
      @(negedge clk);
      checks++;
      if (phase_light !== el) begin
        errors++; $display("FAIL retarget_light c=%0d got=%b exp=%b", c, phase_light, el);
      end
      checks++;
      if (active_phase !== 2'(ea)) begin
        errors++; $display("FAIL retarget_active c=%0d got=%0d exp=%0d", c, active_phase, ea);
      end
      @(posedge clk); #1;
    end
    emerg_req = 1'b0;
  endtask

  task automatic test_reset_mid_yellow();
    do_reset();
    for (int c = 0; c <= 70; c++) begin
      ped_req = (c == 65) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      if (c == 70) begin
        checks++;
        if (phase_light !== lights(2, 1) || ped_pending !== 4'b0100) begin
          errors++; $display("FAIL premid_state light=%b pend=%b exp light=%b pend=0100", phase_light, ped_pending, lights(2, 1));
        end
      end
      @(posedge clk); #1;
    end
    ped_req = '0;
    reset_n = 1'b0;
    #1;
    checks++;
    if (phase_light !== lights(0, 2)) begin
      errors++; $display("FAIL midreset_light got=%b exp=%b", phase_light, lights(0, 2));
    end
    checks++;
    if (walk !== '0 || ped_pending !== '0 || active_phase !== 2'd0) begin
      errors++; $display("FAIL midreset_regs walk=%b pend=%b act=%0d exp 0/0/0", walk, ped_pending, active_phase);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      logic [2*N-1:0] el;
      el = (c < GT) ? lights(0, 2) : lights(0, 1);
      @(negedge clk);
      checks++;
      if (phase_light !== el) begin
        errors++; $display("FAIL postreset_green c=%0d got=%b exp=%b", c, phase_light, el);
      end
      @(posedge clk); #1;
    end
  endtask

  // Reference model: tracks elapsed cycles per state rather than a timer.
  task automatic test_random();
    int ms, mp, mel, mlimit, mwalk_end;
    logic mheld, mres;
    logic [N-1:0] mpend;
    do_reset();
    ms = 0; mp = 0; mel = 0; mlimit = GT; mwalk_end = 0;
    mheld = 1'b0; mres = 1'b0; mpend = '0;
    for (int c = 0; c < 4000; c++) begin
      logic ev, hold, leaving;
      int e, cur, np, nonred;
      logic [N-1:0] ew, npend;
      logic [2*N-1:0] el;
      if (emerg_req) begin
        if ($urandom_range(0, 24) == 0) emerg_req = 1'b0;
      end else if ($urandom_range(0, 79) == 0) begin
        emerg_req = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) emerg_phase = 2'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) ped_req[i] = ($urandom_range(0, 11) == 0);

      ev   = emerg_req;
      e    = int'(emerg_phase);
      hold = (ms == 0) && ev && (e == mp);
      ew   = (ms == 0 && mel < mwalk_end && !hold) ? onehot(mp) : '0;
      el   = lights(mp, (ms == 0) ? 2 : (ms == 1) ? 1 : 0);

      @(negedge clk);
      checks++;
      if (phase_light !== el) begin
        errors++; $display("FAIL rand_light c=%0d got=%b exp=%b", c, phase_light, el);
      end
      checks++;
      if (walk !== ew) begin
        errors++; $display("FAIL rand_walk c=%0d got=%b exp=%b", c, walk, ew);
      end
      checks++;
      if (ped_pending !== mpend) begin
        errors++; $display("FAIL rand_pending c=%0d got=%b exp=%b", c, ped_pending, mpend);
      end
      checks++;
      if (active_phase !== 2'(mp)) begin
        errors++; $display("FAIL rand_active c=%0d got=%0d exp=%0d", c, active_phase, mp);
      end
      nonred = 0;
      for (int i = 0; i < N; i++) begin
        if (phase_light[2*i +: 2] != 2'b00) nonred++;
        if (phase_light[2*i +: 2] == 2'b11) nonred += 10;
      end
      checks++;
      if (nonred > 1) begin
        errors++; $display("FAIL rand_exclusive c=%0d lights=%b", c, phase_light);
      end

      npend = mpend | (ped_req & ~ew);
      cur = mel + 1;
      case (ms)
        0: begin
          if (hold) begin
            mheld = 1'b1;
            mwalk_end = 0;
          end else begin
            leaving = 1'b0;
            if (ev) begin
              leaving = 1'b1;
            end else begin
              if (mheld) mlimit = mel + MG;
              if (cur >= mlimit) leaving = 1'b1;
              else if ((mres || mheld || cur >= MG) && ((mpend & ~onehot(mp)) != '0)) leaving = 1'b1;
            end
            if (leaving) begin
              ms = 1; mel = 0; mheld = 1'b0; mres = 1'b0; mwalk_end = 0;
            end else begin
              mel++;
              if (mheld) begin
                mheld = 1'b0;
                mres = 1'b1;
              end
            end
          end
        end
        1: begin
          if (cur == YT) begin ms = 2; mel = 0; end
          else mel++;
        end
        default: begin
          if (cur == AT) begin
            ms = 0; mel = 0; mlimit = GT; mheld = 1'b0; mres = 1'b0;
            np = ev ? e : (mp + 1) % N;
            if (!ev && mpend[np]) begin
              mwalk_end = WT;
              npend[np] = 1'b0;
            end else begin
              mwalk_end = 0;
            end
            mp = np;
          end else begin
            mel++;
          end
        end
      endcase
      mpend = npend;
      @(posedge clk); #1;
    end
    emerg_req = 1'b0;
    ped_req = '0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_ped_gapout();
    test_walk_ignore();
    test_emergency();
    test_retarget();
    test_reset_mid_yellow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
